// File: rtl/fpga_transmitter.sv
// Transmit end of the FPGA-to-FPGA serial link.
// A one-entry holding buffer accepts parallel bytes. Each byte is shifted out
// MSB-first with a send qualifier, followed by a one-cycle finish pulse and a
// four-phase handshake on the receiver's acknowledge, guarded by a timeout.
//
//   state          | meaning
//   ---------------+------------------------------------------------------
//   S_IDLE         | no frame in flight; starts when buffer full and ack=0
//   S_SHIFT        | one bit per cycle on o_data, o_send=1
//   S_FINISH       | one-cycle o_finish pulse after the last bit
//   S_WAIT_ACK     | waiting for acknowledge=1, bounded by ACK_TIMEOUT
//   S_WAIT_RELEASE | waiting for acknowledge=0 to close the handshake
module fpga_transmitter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_load,
    output logic                  o_ready,
    output logic                  o_data,
    output logic                  o_send,
    output logic                  o_finish,
    input  logic                  i_acknowledge,
    output logic                  o_busy,
    output logic                  o_timeout_error
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_SHIFT        = 3'd1,
        S_FINISH       = 3'd2,
        S_WAIT_ACK     = 3'd3,
        S_WAIT_RELEASE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_buf;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic                    r_ready;
    logic                    r_data;
    logic                    r_send;
    logic                    r_finish;
    logic                    r_busy;
    logic                    r_timeout_error;

    logic                    w_accept;
    logic                    w_start;
    logic                    w_timeout;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic                    w_ready_next;
    logic                    w_data_next;
    logic                    w_send_next;
    logic                    w_finish_next;
    logic                    w_busy_next;
    logic                    w_err_next;

    // r_ready doubles as the "holding buffer empty" flag.
    assign w_accept  = i_load && r_ready;
    assign w_start   = (r_state == S_IDLE) && !r_ready && !i_acknowledge;
    assign w_timeout = (r_state == S_WAIT_ACK) && !i_acknowledge && (r_tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:         if (w_start) w_state_next = S_SHIFT;
            S_SHIFT:        if (r_bit_cnt == BIT_LAST) w_state_next = S_FINISH;
            S_FINISH:       w_state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (i_acknowledge)      w_state_next = S_WAIT_RELEASE;
                else if (w_timeout)     w_state_next = S_IDLE;
            end
            S_WAIT_RELEASE: if (!i_acknowledge) w_state_next = S_IDLE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered
    // so that every output lines up with its state without a combinational path.
    always_comb begin
        w_shift_next  = r_shift;
        if (w_start) begin
            w_shift_next = r_buf;
        end else if (r_state == S_SHIFT) begin
            w_shift_next = r_shift << 1;
        end
        w_ready_next  = r_ready;
        if (w_accept) begin
            w_ready_next = 1'b0;
        end else if (w_start) begin
            w_ready_next = 1'b1;
        end
        w_err_next    = r_timeout_error;
        if (w_start) begin
            w_err_next = 1'b0;
        end else if (w_timeout) begin
            w_err_next = 1'b1;
        end
        w_send_next   = (w_state_next == S_SHIFT);
        w_data_next   = (w_state_next == S_SHIFT) && w_shift_next[DATA_WIDTH-1];
        w_finish_next = (w_state_next == S_FINISH);
        w_busy_next   = (w_state_next != S_IDLE);
    end

    // Datapath, counters and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_buf           <= '0;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_tmo_cnt       <= '0;
            r_ready         <= 1'b1;
            r_data          <= 1'b0;
            r_send          <= 1'b0;
            r_finish        <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf <= i_data_in;
            end
            r_shift <= w_shift_next;
            if (w_start) begin
                r_bit_cnt <= '0;
            end else if ((r_state == S_SHIFT) && (r_bit_cnt != BIT_LAST)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == S_FINISH) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT_ACK) && !i_acknowledge && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            r_ready         <= w_ready_next;
            r_data          <= w_data_next;
            r_send          <= w_send_next;
            r_finish        <= w_finish_next;
            r_busy          <= w_busy_next;
            r_timeout_error <= w_err_next;
        end
    end

    assign o_ready         = r_ready;
    assign o_data          = r_data;
    assign o_send          = r_send;
    assign o_finish        = r_finish;
    assign o_busy          = r_busy;
    assign o_timeout_error = r_timeout_error;

endmodule

// File: tb/tb_fpga_transmitter.sv
// Bench for fpga_transmitter: the expected waveform of each frame is laid out
// from the link's timing rules (one idle cycle, DATA_WIDTH bit cycles, finish,
// handshake or timeout), with random bytes, ack delays, holds and preloads.
module tb_fpga_transmitter;
    localparam int DW  = 8;
    localparam int TMO = 255;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       load = 1'b0;
    logic       ack  = 1'b0;
    logic [7:0] din  = 8'h00;
    logic       ready, data, send, finish, busy, terr;

    int n_chk  = 0;
    int n_pass = 0;

    fpga_transmitter #(.DATA_WIDTH(DW), .ACK_TIMEOUT(TMO)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_data_in       (din),
        .i_load          (load),
        .o_ready         (ready),
        .o_data          (data),
        .o_send          (send),
        .o_finish        (finish),
        .i_acknowledge   (ack),
        .o_busy          (busy),
        .o_timeout_error (terr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry: either the cycle before the load (do_load) or the idle cycle with a
    // byte already buffered. Exit: the first idle cycle after the frame.
    task automatic run_frame(input logic [7:0] b, input bit do_load, input bit err_before,
                             input int ack_dly, input int ack_hold, input bit glitch,
                             input bit pre, input logic [7:0] nb, input int pre_at,
                             output bit timed_out);
        if (do_load) begin
            din  = b;
            load = 1'b1;
            tick();
            load = 1'b0;
            din  = 8'($urandom);
        end
        chk("idle_busy",  int'(busy),  0);
        chk("idle_ready", int'(ready), 0);
        chk("idle_send",  int'(send),  0);
        chk("idle_err",   int'(terr),  int'(err_before));
        tick();
        for (int i = 0; i < DW; i++) begin
            chk("shift_send",   int'(send),   1);
            chk("shift_data",   int'(data),   int'(b[DW-1-i]));
            chk("shift_busy",   int'(busy),   1);
            chk("shift_err",    int'(terr),   0);
            chk("shift_finish", int'(finish), 0);
            chk("shift_ready",  int'(ready),  (pre && i > pre_at) ? 0 : 1);
            load = 1'b0;
            ack  = 1'b0;
            if (pre && i == pre_at) begin
                din  = nb;
                load = 1'b1;
            end else if (pre && i == pre_at + 1) begin
                din  = ~nb;
                load = 1'b1;
            end
            if (glitch && i == 3) ack = 1'b1;
            tick();
        end
        load = 1'b0;
        ack  = 1'b0;
        chk("fin_pulse", int'(finish), 1);
        chk("fin_send",  int'(send),   0);
        chk("fin_data",  int'(data),   0);
        chk("fin_busy",  int'(busy),   1);
        tick();
        chk("wack_finish", int'(finish), 0);
        timed_out = (ack_dly >= TMO);
        if (timed_out) begin
            for (int k = 0; k < TMO; k++) begin
                chk("wack_busy", int'(busy), 1);
                chk("wack_err",  int'(terr), 0);
                tick();
            end
            chk("tmo_busy",  int'(busy),  0);
            chk("tmo_err",   int'(terr),  1);
            chk("tmo_send",  int'(send),  0);
            chk("tmo_ready", int'(ready), pre ? 0 : 1);
        end else begin
            for (int k = 0; k < ack_dly; k++) begin
                chk("wack_busy", int'(busy), 1);
                tick();
            end
            ack = 1'b1;
            tick();
            for (int j = 1; j < ack_hold; j++) begin
                chk("rel_busy", int'(busy), 1);
                tick();
            end
            ack = 1'b0;
            chk("rel_busy", int'(busy), 1);
            tick();
            chk("done_busy",  int'(busy),  0);
            chk("done_err",   int'(terr),  0);
            chk("done_send",  int'(send),  0);
            chk("done_ready", int'(ready), pre ? 0 : 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         to;
        bit         pend;
        bit         err;
        bit         gl;
        bit         pre;
        logic [7:0] b;
        logic [7:0] nb;
        logic [7:0] pb;
        int         dly;
        int         hold;
        int         pa;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready",  int'(ready),  1);
        chk("rst_data",   int'(data),   0);
        chk("rst_send",   int'(send),   0);
        chk("rst_finish", int'(finish), 0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_err",    int'(terr),   0);
        rst = 1'b0;
        tick();

        // A5 with ack raised three cycles after finish, held two cycles.
        run_frame(8'hA5, 1'b1, 1'b0, 2, 2, 1'b0, 1'b0, 8'h00, 0, to);

        // 3C with FF preloaded mid-shift and 00 offered while the buffer is full.
        run_frame(8'h3C, 1'b1, 1'b0, 1, 1, 1'b0, 1'b1, 8'hFF, 3, to);
        run_frame(8'hFF, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 8'h00, 0, to);

        // 81 never acknowledged, then a fresh frame clears the error at start.
        run_frame(8'h81, 1'b1, 1'b0, TMO + 10, 1, 1'b0, 1'b0, 8'h00, 0, to);
        chk("tp4_timed_out", int'(to), 1);
        run_frame(8'($urandom), 1'b1, 1'b1, 4, 3, 1'b0, 1'b0, 8'h00, 0, to);

        // Stale acknowledge in idle blocks the start; ack pulse mid-shift is ignored.
        ack  = 1'b1;
        din  = 8'h55;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stale_send", int'(send), 0);
            chk("stale_busy", int'(busy), 0);
            tick();
        end
        ack = 1'b0;
        run_frame(8'h55, 1'b0, 1'b0, 1, 2, 1'b1, 1'b0, 8'h00, 0, to);

        // Randomised frames.
        pend = 1'b0;
        err  = 1'b0;
        pb   = 8'h00;
        for (int f = 0; f < 12; f++) begin
            b    = pend ? pb : 8'($urandom);
            dly  = ($urandom_range(0, 5) == 0) ? TMO + 5 : int'($urandom_range(0, 12));
            hold = int'($urandom_range(1, 4));
            gl   = 1'($urandom_range(0, 1));
            pre  = (f < 11) && ($urandom_range(0, 1) == 1);
            nb   = 8'($urandom);
            pa   = int'($urandom_range(0, 6));
            run_frame(b, !pend, err, dly, hold, gl, pre, nb, pa, to);
            pend = pre;
            pb   = nb;
            err  = to;
        end

        // Reset during the fourth bit of F0 clears outputs without a clock edge.
        din  = 8'hF0;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("f0_send_before", int'(send), 1);
        chk("f0_data_before", int'(data), 1);
        rst = 1'b1;
        #1;
        chk("async_send",   int'(send),   0);
        chk("async_data",   int'(data),   0);
        chk("async_finish", int'(finish), 0);
        chk("async_busy",   int'(busy),   0);
        chk("async_ready",  int'(ready),  1);
        chk("async_err",    int'(terr),   0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("post_rst_send",   int'(send),   0);
            chk("post_rst_busy",   int'(busy),   0);
            chk("post_rst_finish", int'(finish), 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
